// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multi-cycle RV32I main control: FSM states, opcodes
// and datapath mux selects.
package multicycle_control_unit_pkg;

   typedef enum logic [2:0] {
      ST_IF    = 3'd0,
      ST_ID    = 3'd1,
      ST_EX    = 3'd2,
      ST_MEM   = 3'd3,
      ST_WB    = 3'd4,
      ST_JALR2 = 3'd5,
      ST_PC4   = 3'd6,
      ST_HALT  = 3'd7
   } state_t;

   localparam logic [6:0] OPC_ARITHMETIC     = 7'b0110011;
   localparam logic [6:0] OPC_ARITHMETIC_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD           = 7'b0000011;
   localparam logic [6:0] OPC_STORE          = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH         = 7'b1100011;
   localparam logic [6:0] OPC_JAL            = 7'b1101111;
   localparam logic [6:0] OPC_JALR           = 7'b1100111;
   localparam logic [6:0] OPC_ECALL          = 7'b1110011;

   localparam logic OP_SIG_ADD = 1'b0;
   localparam logic OP_SIG_ALU = 1'b1;

   localparam logic ALU_SRC_A_PC  = 1'b0;
   localparam logic ALU_SRC_A_REG = 1'b1;

   localparam logic [1:0] ALU_SRC_B_REG  = 2'd0;
   localparam logic [1:0] ALU_SRC_B_FOUR = 2'd1;
   localparam logic [1:0] ALU_SRC_B_IMM  = 2'd2;

   localparam logic [1:0] WB_SEL_ALUOUT = 2'd0;
   localparam logic [1:0] WB_SEL_MDR    = 2'd1;
   localparam logic [1:0] WB_SEL_ALU    = 2'd2;

   localparam logic PC_SRC_ALU    = 1'b0;
   localparam logic PC_SRC_ALUOUT = 1'b1;

   // Opcodes that go through the EX state (ECALL is decoded separately in ID).
   function automatic logic goes_to_ex(input logic [6:0] op);
      return (op == OPC_ARITHMETIC) || (op == OPC_ARITHMETIC_IMM) ||
             (op == OPC_LOAD) || (op == OPC_STORE) || (op == OPC_BRANCH) ||
             (op == OPC_JAL) || (op == OPC_JALR);
   endfunction

endpackage

// File: rtl/multicycle_control_unit_mem_wait_watchdog.sv
// Memory wait-cycle counter; expired flags the last cycle an access may still
// complete before the control FSM gives up.
module mem_wait_watchdog #(
   parameter int MAX_MEM_WAIT = 15,
   parameter int CNT_W        = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_MEM_WAIT - 1);

   logic [CNT_W-1:0] wait_cnt_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt_reg <= '0;
      end else if (clear) begin
         wait_cnt_reg <= '0;
      end else if (count_en && (wait_cnt_reg != LAST_CNT)) begin
         wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end
   end

   assign expired = (wait_cnt_reg == LAST_CNT);

endmodule

// File: rtl/multicycle_control_unit.sv
// Main-control FSM of the multi-cycle RV32I CPU: sequences IF/ID/EX/MEM/WB over
// the shared ALU and unified memory, halting on ECALL, illegal opcode or timeout.
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
#(
   parameter int MAX_MEM_WAIT = 15,
   parameter int CNT_W        = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic       alu_bcond,
   input  logic       ecall_halt,
   input  logic       mem_ready,
   output logic       mem_read,
   output logic       mem_write,
   output logic       i_or_d,
   output logic       ir_write,
   output logic       mdr_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       alu_op_sig,
   output logic       pc_source,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] wb_sel,
   output logic       halted,
   output logic       illegal_inst,
   output logic       mem_timeout
);

   state_t state_reg, state_next, dec_state;
   logic   halted_reg, illegal_reg, timeout_reg;
   logic   illegal_hit, timeout_hit, wd_expired, wd_clear, wd_count_en;

   // Decoding as HALT while reset is low forces every strobe to 0 immediately.
   assign dec_state = reset ? state_reg : ST_HALT;

   assign wd_clear    = (state_next != state_reg);
   assign wd_count_en = ((state_reg == ST_IF) || (state_reg == ST_MEM)) && !mem_ready;

   mem_wait_watchdog #(
      .MAX_MEM_WAIT(MAX_MEM_WAIT),
      .CNT_W       (CNT_W)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (wd_clear),
      .count_en(wd_count_en),
      .expired (wd_expired)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= ST_IF;
         halted_reg  <= 1'b0;
         illegal_reg <= 1'b0;
         timeout_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_next == ST_HALT) halted_reg  <= 1'b1;
         if (illegal_hit)           illegal_reg <= 1'b1;
         if (timeout_hit)           timeout_reg <= 1'b1;
      end
   end

   always_comb begin
      state_next  = dec_state;
      illegal_hit = 1'b0;
      timeout_hit = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      i_or_d      = 1'b0;
      ir_write    = 1'b0;
      mdr_write   = 1'b0;
      alu_src_a   = ALU_SRC_A_PC;
      alu_src_b   = ALU_SRC_B_REG;
      alu_op_sig  = OP_SIG_ADD;
      pc_source   = PC_SRC_ALU;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      wb_sel      = WB_SEL_ALUOUT;

      case (dec_state)
         ST_IF: begin
            mem_read = 1'b1;
            ir_write = mem_ready;
            if (mem_ready) begin
               state_next = ST_ID;
            end else if (wd_expired) begin
               state_next  = ST_HALT;
               timeout_hit = 1'b1;
            end
         end
         ST_ID: begin
            alu_src_b = ALU_SRC_B_IMM;
            if (opcode == OPC_ECALL) begin
               state_next = ecall_halt ? ST_HALT : ST_WB;
            end else if (goes_to_ex(opcode)) begin
               state_next = ST_EX;
            end else begin
               state_next  = ST_HALT;
               illegal_hit = 1'b1;
            end
         end
         ST_EX: begin
            alu_src_a  = ALU_SRC_A_REG;
            alu_op_sig = OP_SIG_ALU;
            case (opcode)
               OPC_ARITHMETIC: state_next = ST_WB;
               OPC_ARITHMETIC_IMM: begin
                  alu_src_b  = ALU_SRC_B_IMM;
                  state_next = ST_WB;
               end
               OPC_LOAD, OPC_STORE: begin
                  alu_src_b  = ALU_SRC_B_IMM;
                  state_next = ST_MEM;
               end
               OPC_BRANCH: begin
                  pc_source  = alu_bcond ? PC_SRC_ALUOUT : PC_SRC_ALU;
                  pc_write   = alu_bcond;
                  state_next = alu_bcond ? ST_IF : ST_PC4;
               end
               OPC_JAL: begin
                  alu_src_a  = ALU_SRC_A_PC;
                  alu_src_b  = ALU_SRC_B_FOUR;
                  alu_op_sig = OP_SIG_ADD;
                  reg_write  = 1'b1;
                  wb_sel     = WB_SEL_ALU;
                  pc_source  = PC_SRC_ALUOUT;
                  pc_write   = 1'b1;
                  state_next = ST_IF;
               end
               OPC_JALR: begin
                  alu_src_b  = ALU_SRC_B_IMM;
                  state_next = ST_JALR2;
               end
               default: state_next = ST_HALT;
            endcase
         end
         ST_MEM: begin
            i_or_d    = 1'b1;
            mem_write = (opcode == OPC_STORE);
            mem_read  = (opcode != OPC_STORE);
            mdr_write = mem_ready && (opcode == OPC_LOAD);
            if (mem_ready) begin
               state_next = ST_WB;
            end else if (wd_expired) begin
               state_next  = ST_HALT;
               timeout_hit = 1'b1;
            end
         end
         ST_WB: begin
            alu_src_b  = ALU_SRC_B_FOUR;
            pc_write   = 1'b1;
            state_next = ST_IF;
            if ((opcode == OPC_ARITHMETIC) || (opcode == OPC_ARITHMETIC_IMM)) begin
               reg_write = 1'b1;
            end else if (opcode == OPC_LOAD) begin
               reg_write = 1'b1;
               wb_sel    = WB_SEL_MDR;
            end
         end
         ST_JALR2: begin
            // Target comes from ALUOut computed in EX, so overwriting rd==rs1 here is safe.
            alu_src_b  = ALU_SRC_B_FOUR;
            reg_write  = 1'b1;
            wb_sel     = WB_SEL_ALU;
            pc_source  = PC_SRC_ALUOUT;
            pc_write   = 1'b1;
            state_next = ST_IF;
         end
         ST_PC4: begin
            alu_src_b  = ALU_SRC_B_FOUR;
            pc_write   = 1'b1;
            state_next = ST_IF;
         end
         ST_HALT: state_next = ST_HALT;
         default: state_next = ST_HALT;
      endcase
   end

   assign halted       = halted_reg;
   assign illegal_inst = illegal_reg;
   assign mem_timeout  = timeout_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized instruction-level bench: expected per-cycle control vectors are
// queued by the stimulus side and checked by an independent negedge monitor.
module tb_multicycle_control_unit;

   localparam int MAXW = 4;

   localparam logic [6:0] OP_R    = 7'h33;
   localparam logic [6:0] OP_I    = 7'h13;
   localparam logic [6:0] OP_LD   = 7'h03;
   localparam logic [6:0] OP_ST   = 7'h23;
   localparam logic [6:0] OP_BR   = 7'h63;
   localparam logic [6:0] OP_JAL  = 7'h6F;
   localparam logic [6:0] OP_JALR = 7'h67;
   localparam logic [6:0] OP_SYS  = 7'h73;

   logic       clk, reset, alu_bcond, ecall_halt, mem_ready;
   logic [6:0] opcode;
   logic       mem_read, mem_write, i_or_d, ir_write, mdr_write, alu_src_a;
   logic [1:0] alu_src_b, wb_sel;
   logic       alu_op_sig, pc_source, pc_write, reg_write;
   logic       halted, illegal_inst, mem_timeout;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       i_or_d;
      logic       ir_write;
      logic       mdr_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       alu_op_sig;
      logic       pc_source;
      logic       pc_write;
      logic       reg_write;
      logic [1:0] wb_sel;
      logic       halted;
      logic       illegal_inst;
      logic       mem_timeout;
   } ctl_t;

   typedef struct {
      ctl_t  c;
      string tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   multicycle_control_unit #(
      .MAX_MEM_WAIT(MAXW),
      .CNT_W       (3)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .opcode      (opcode),
      .alu_bcond   (alu_bcond),
      .ecall_halt  (ecall_halt),
      .mem_ready   (mem_ready),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .i_or_d      (i_or_d),
      .ir_write    (ir_write),
      .mdr_write   (mdr_write),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .alu_op_sig  (alu_op_sig),
      .pc_source   (pc_source),
      .pc_write    (pc_write),
      .reg_write   (reg_write),
      .wb_sel      (wb_sel),
      .halted      (halted),
      .illegal_inst(illegal_inst),
      .mem_timeout (mem_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: one expected vector per clock, compared mid-cycle.
   always @(negedge clk) begin
      exp_t x;
      ctl_t g;
      if (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         g = {mem_read, mem_write, i_or_d, ir_write, mdr_write, alu_src_a, alu_src_b,
              alu_op_sig, pc_source, pc_write, reg_write, wb_sel,
              halted, illegal_inst, mem_timeout};
         n_vec++;
         if (g !== x.c) begin
            n_err++;
            $display("FAIL vec %0d [%s]: got %b required %b", n_vec, x.tag, g, x.c);
         end
      end
   end

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [6:0] junk_op();
      return 7'($urandom_range(0, 127));
   endfunction

   function automatic ctl_t alu(input logic a, input logic [1:0] b, input logic op);
      ctl_t e;
      e = '0;
      e.alu_src_a  = a;
      e.alu_src_b  = b;
      e.alu_op_sig = op;
      return e;
   endfunction

   task automatic step(input ctl_t e, input string tag, input logic rst, input logic mr,
                       input logic bc, input logic eh, input logic [6:0] op);
      exp_t x;
      @(posedge clk);
      #1;
      reset      = rst;
      mem_ready  = mr;
      alu_bcond  = bc;
      ecall_halt = eh;
      opcode     = op;
      x.c   = e;
      x.tag = tag;
      exp_q.push_back(x);
   endtask

   task automatic do_reset();
      repeat (2) step('0, "reset", 1'b0, rb(), rb(), rb(), junk_op());
   endtask

   task automatic halt_phase(input logic ill, input logic to, input logic [6:0] op);
      ctl_t e;
      e = '0;
      e.halted       = 1'b1;
      e.illegal_inst = ill;
      e.mem_timeout  = to;
      repeat (2) step(e, "halt", 1'b1, rb(), rb(), rb(), op);
      do_reset();
   endtask

   // A memory access that sees w cycles without mem_ready before completing;
   // w >= MAXW means the watchdog gives up after MAXW waiting cycles.
   task automatic mem_phase(input ctl_t base, input ctl_t on_ready, input string tag,
                            input int w, input logic [6:0] op, output bit to);
      to = 1'b0;
      for (int i = 0; i < w && i < MAXW; i++)
         step(base, {tag, "_wait"}, 1'b1, 1'b0, rb(), rb(), op);
      if (w >= MAXW) begin
         to = 1'b1;
         halt_phase(1'b0, 1'b1, op);
      end else begin
         step(on_ready, {tag, "_ready"}, 1'b1, 1'b1, rb(), rb(), op);
      end
   endtask

   task automatic wb_step(input logic rw, input logic [1:0] sel, input logic [6:0] op);
      ctl_t e;
      e = alu(1'b0, 2'd1, 1'b0);
      e.pc_write  = 1'b1;
      e.reg_write = rw;
      e.wb_sel    = sel;
      step(e, "wb", 1'b1, rb(), rb(), rb(), op);
   endtask

   task automatic run_instr(input logic [6:0] op, input int wif, input int wmem,
                            input logic bcond, input logic eh);
      ctl_t e, r;
      bit   to;
      e = '0;
      e.mem_read = 1'b1;
      r = e;
      r.ir_write = 1'b1;
      mem_phase(e, r, "if", wif, junk_op(), to);
      if (to) return;
      step(alu(1'b0, 2'd2, 1'b0), "id", 1'b1, rb(), rb(), eh, op);
      case (op)
         OP_R, OP_I: begin
            step(alu(1'b1, (op == OP_R) ? 2'd0 : 2'd2, 1'b1), "ex_arith", 1'b1, rb(), rb(), rb(), op);
            wb_step(1'b1, 2'd0, op);
         end
         OP_LD, OP_ST: begin
            step(alu(1'b1, 2'd2, 1'b1), "ex_addr", 1'b1, rb(), rb(), rb(), op);
            e = '0;
            e.i_or_d    = 1'b1;
            e.mem_read  = (op == OP_LD);
            e.mem_write = (op == OP_ST);
            r = e;
            r.mdr_write = (op == OP_LD);
            mem_phase(e, r, "mem", wmem, op, to);
            if (to) return;
            wb_step(op == OP_LD, (op == OP_LD) ? 2'd1 : 2'd0, op);
         end
         OP_BR: begin
            e = alu(1'b1, 2'd0, 1'b1);
            e.pc_source = bcond;
            e.pc_write  = bcond;
            step(e, "ex_branch", 1'b1, rb(), bcond, rb(), op);
            if (!bcond) begin
               e = alu(1'b0, 2'd1, 1'b0);
               e.pc_write = 1'b1;
               step(e, "pc4", 1'b1, rb(), rb(), rb(), op);
            end
         end
         OP_JAL, OP_JALR: begin
            if (op == OP_JALR) step(alu(1'b1, 2'd2, 1'b1), "ex_jalr", 1'b1, rb(), rb(), rb(), op);
            e = alu(1'b0, 2'd1, 1'b0);
            e.reg_write = 1'b1;
            e.wb_sel    = 2'd2;
            e.pc_source = 1'b1;
            e.pc_write  = 1'b1;
            step(e, (op == OP_JAL) ? "ex_jal" : "jalr2", 1'b1, rb(), rb(), rb(), op);
         end
         OP_SYS: begin
            if (eh) halt_phase(1'b0, 1'b0, op);
            else    wb_step(1'b0, 2'd0, op);
         end
         default: halt_phase(1'b1, 1'b0, op);
      endcase
   endtask

   logic [6:0] op_tab [11];

   initial begin
      int k, wif, wmem;
      ctl_t e;
      op_tab = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_SYS, 7'h7F, 7'h37, 7'h17};
      reset = 1'b0; mem_ready = 1'b0; alu_bcond = 1'b0; ecall_halt = 1'b0; opcode = '0;
      do_reset();

      run_instr(OP_R, 0, 0, 1'b0, 1'b0);
      run_instr(OP_LD, 0, 3, 1'b0, 1'b0);
      run_instr(OP_BR, 0, 0, 1'b1, 1'b0);
      run_instr(OP_BR, 0, 0, 1'b0, 1'b0);
      run_instr(OP_JALR, 0, 0, 1'b0, 1'b0);
      run_instr(OP_JAL, 1, 0, 1'b0, 1'b0);
      run_instr(OP_ST, MAXW - 1, MAXW - 1, 1'b0, 1'b0);
      run_instr(OP_SYS, 0, 0, 1'b0, 1'b0);
      run_instr(7'h7F, 0, 0, 1'b0, 1'b0);
      run_instr(OP_SYS, 0, 0, 1'b0, 1'b1);
      run_instr(OP_R, MAXW, 0, 1'b0, 1'b0);
      run_instr(OP_ST, 0, MAXW, 1'b0, 1'b0);

      // Reset pulled low during a stalled load: strobes drop at once, then IF.
      e = '0; e.mem_read = 1'b1; e.ir_write = 1'b1;
      step(e, "if_ready", 1'b1, 1'b1, rb(), rb(), junk_op());
      step(alu(1'b0, 2'd2, 1'b0), "id", 1'b1, rb(), rb(), rb(), OP_LD);
      step(alu(1'b1, 2'd2, 1'b1), "ex_addr", 1'b1, rb(), rb(), rb(), OP_LD);
      e = '0; e.i_or_d = 1'b1; e.mem_read = 1'b1;
      step(e, "mem_wait", 1'b1, 1'b0, rb(), rb(), OP_LD);
      step('0, "rst_mid_mem", 1'b0, 1'b0, rb(), rb(), OP_LD);
      do_reset();
      run_instr(OP_I, 0, 0, 1'b0, 1'b0);

      for (int n = 0; n < 200; n++) begin
         k    = $urandom_range(0, 10);
         wif  = ($urandom_range(0, 9) == 0) ? MAXW : $urandom_range(0, MAXW - 1);
         wmem = ($urandom_range(0, 9) == 0) ? MAXW : $urandom_range(0, MAXW - 1);
         run_instr(op_tab[k], wif, wmem, rb(), rb());
      end

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
